ahb_ram_responder: RTL and testbench



---
 rtl/ahb_ram_responder.sv | 156 +++++++++++++++
 tb/tb_ahb_ram_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_ram_responder.sv
// ahb_ram_responder: AHB-Lite subordinate in front of a word-organised RAM.
// Handles single transfers only. NONSEQ and SEQ behave the same, and there is no
// burst address generation. Every OKAY data phase has WAIT_STATES low-ready cycles.
// Writes can be byte, halfword or word, and they commit at the end of the DATA cycle.
// Reads return the full word combinationally during DATA.
// Optional feature macro: AHB_RAM_ERRRESP_EN. When it is defined, out-of-range,
// misaligned or oversized transfers get a two-cycle ERROR response.
// When it is undefined, the upper address bits alias, the low address bits are
// ignored for alignment, oversized transfers act as word transfers, and HRESP is always 0.
module ahb_ram_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int WORDS = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state_q;
    logic [3:0]              waitCnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              size_q;
    logic                    write_q;
    logic                    ready_q;
    logic                    resp_q;

    logic [31:0]             mem [WORDS];

    logic                    accept;
    logic                    reqErr;
    logic [3:0]              byteEn_d;
    logic [ADDR_WIDTH-3:0]   wordIdx;
    logic                    unused_ok;

    assign accept  = HSEL & HTRANS[1] & HREADY;
    assign wordIdx = addr_q[ADDR_WIDTH-1:2];

`ifdef AHB_RAM_ERRRESP_EN
    // An address phase is illegal if it falls outside the RAM, is misaligned, or is wider than a word.
    always_comb begin
        reqErr = 1'b0;
        if (HADDR[31:ADDR_WIDTH] != '0)
            reqErr = 1'b1;
        if (HSIZE == 3'b001 && HADDR[0])
            reqErr = 1'b1;
        if (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
            reqErr = 1'b1;
        if (HSIZE > 3'b010)
            reqErr = 1'b1;
    end
    assign unused_ok = HTRANS[0];
`else
    assign reqErr    = 1'b0;
    assign unused_ok = ^{HTRANS[0], HADDR[31:ADDR_WIDTH]};
`endif

    // Byte-lane enables for the latched transfer, using little-endian lane mapping.
    always_comb begin
        byteEn_d = 4'b0000;
        case (size_q)
            3'b000:  byteEn_d = 4'b0001 << addr_q[1:0];
            3'b001:  byteEn_d = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byteEn_d = 4'b1111;
        endcase
    end

    // Transfer sequencing: accept, optional waits or error, and completion, with registered ready/resp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            waitCnt_q <= 4'd0;
            addr_q    <= '0;
            size_q    <= 3'b000;
            write_q   <= 1'b0;
            ready_q   <= 1'b1;
            resp_q    <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (waitCnt_q == 4'd0) begin
                        state_q <= S_DATA;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end else begin
                        waitCnt_q <= waitCnt_q - 4'd1;
                    end
                end
                S_ERR1: begin
                    state_q <= S_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        addr_q  <= HADDR[ADDR_WIDTH-1:0];
                        size_q  <= HSIZE;
                        write_q <= HWRITE;
                        if (reqErr) begin
                            state_q <= S_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state_q   <= S_WAIT;
                            waitCnt_q <= 4'(WAIT_STATES - 1);
                            ready_q   <= 1'b0;
                            resp_q    <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Commit write data lanes on the edge that ends a write DATA cycle; a reset in progress drops the write.
    always_ff @(posedge clk) begin
        if (reset && state_q == S_DATA && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn_d[i])
                    mem[wordIdx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA    = (state_q == S_DATA && !write_q) ? mem[wordIdx] : 32'h0;
    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;

endmodule

// File: tb/tb_ahb_ram_responder.sv
// Testbench for ahb_ram_responder. It uses one instance with one wait state and one
// zero-wait instance. Single transfers come from a vector table. The reset-abort,
// idle/busy, pipelined and error cases are written out by hand.
module tb_ahb_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        hsel1, hwrite1;
    logic [31:0] haddr1, hwdata1, hrdata1;
    logic [1:0]  htrans1;
    logic [2:0]  hsize1;
    logic        hreadyout1, hresp1;

    logic        hsel0, hwrite0;
    logic [31:0] haddr0, hwdata0, hrdata0;
    logic [1:0]  htrans0;
    logic [2:0]  hsize0;
    logic        hreadyout0, hresp0;

    int checks = 0;
    int errors = 0;

    ahb_ram_responder #(.ADDR_WIDTH(12), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .HSEL(hsel1), .HADDR(haddr1), .HTRANS(htrans1),
        .HWRITE(hwrite1), .HSIZE(hsize1), .HWDATA(hwdata1), .HREADY(hreadyout1),
        .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1)
    );

    ahb_ram_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr0), .HTRANS(htrans0),
        .HWRITE(hwrite0), .HSIZE(hsize0), .HWDATA(hwdata0), .HREADY(hreadyout0),
        .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          expWaits;
        logic        expLowResp;
        logic        expResp;
        logic        chkData;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int expWaits, input logic expLowResp,
                          input logic expResp, input logic chkData, input logic [31:0] expData);
        vec_t v;
        v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.expWaits = expWaits; v.expLowResp = expLowResp; v.expResp = expResp;
        v.chkData = chkData; v.expData = expData;
        vecs.push_back(v);
    endtask

    // Single transfer on the one-wait instance, started at a negedge with that instance idle.
    task automatic applyStimulus(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output int waits, output logic resp, output logic lowResp);
        hsel1 = 1'b1; htrans1 = 2'b10; hwrite1 = wr; hsize1 = size; haddr1 = addr;
        @(negedge clk);
        hsel1 = 1'b0; htrans1 = 2'b00; hwdata1 = wdata;
        waits = 0;
        lowResp = 1'b0;
        while (hreadyout1 !== 1'b1 && waits < 20) begin
            if (waits == 0) lowResp = hresp1;
            waits++;
            @(negedge clk);
        end
        rdata = hrdata1;
        resp  = hresp1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] rdata;
        int          waits;
        logic        resp, lowResp;

        hsel1 = 0; htrans1 = 0; hwrite1 = 0; hsize1 = 0; haddr1 = 0; hwdata1 = 0;
        hsel0 = 0; htrans0 = 0; hwrite0 = 0; hsize0 = 0; haddr0 = 0; hwdata0 = 0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst.ready1", 32'(hreadyout1), 32'd1);
        checkOutput("rst.resp1",  32'(hresp1),     32'd0);
        checkOutput("rst.rdata1", hrdata1,         32'h0);
        checkOutput("rst.ready0", 32'(hreadyout0), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // A halfword at 0x040 covers lanes 1 and 0, so it overwrites the 0x11 byte at 0x041.
        addVec(1, 3'b010, 32'h020, 32'hDEADBEEF, 1, 0, 0, 0, 32'h0);
        addVec(0, 3'b010, 32'h020, 32'hFFFFFFFF, 1, 0, 0, 1, 32'hDEADBEEF);
        addVec(1, 3'b010, 32'h040, 32'h00000000, 1, 0, 0, 0, 32'h0);
        addVec(1, 3'b000, 32'h041, 32'h00001100, 1, 0, 0, 0, 32'h0);
        addVec(1, 3'b000, 32'h043, 32'h22000000, 1, 0, 0, 0, 32'h0);
        addVec(0, 3'b010, 32'h040, 32'hFFFFFFFF, 1, 0, 0, 1, 32'h22001100);
        addVec(1, 3'b001, 32'h040, 32'h0000ABCD, 1, 0, 0, 0, 32'h0);
        addVec(0, 3'b010, 32'h040, 32'hFFFFFFFF, 1, 0, 0, 1, 32'h2200ABCD);
        addVec(1, 3'b001, 32'h042, 32'h12340000, 1, 0, 0, 0, 32'h0);
        addVec(0, 3'b000, 32'h041, 32'hFFFFFFFF, 1, 0, 0, 1, 32'h1234ABCD);
        addVec(1, 3'b010, 32'h000, 32'h0BADC0DE, 1, 0, 0, 0, 32'h0);
`ifdef AHB_RAM_ERRRESP_EN
        addVec(1, 3'b010, 32'h00002000, 32'h55AA55AA, 1, 1, 1, 0, 32'h0);
        addVec(0, 3'b010, 32'h000, 32'hFFFFFFFF, 1, 0, 0, 1, 32'h0BADC0DE);
        addVec(1, 3'b010, 32'h042, 32'h77777777, 1, 1, 1, 0, 32'h0);
        addVec(0, 3'b010, 32'h040, 32'hFFFFFFFF, 1, 0, 0, 1, 32'h1234ABCD);
`else
        addVec(1, 3'b010, 32'h00002000, 32'h55AA55AA, 1, 0, 0, 0, 32'h0);
        addVec(0, 3'b010, 32'h000, 32'hFFFFFFFF, 1, 0, 0, 1, 32'h55AA55AA);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                          rdata, waits, resp, lowResp);
            checkOutput($sformatf("vec%0d.waits", i), 32'(waits), 32'(vecs[i].expWaits));
            checkOutput($sformatf("vec%0d.lowResp", i), 32'(lowResp), 32'(vecs[i].expLowResp));
            checkOutput($sformatf("vec%0d.resp", i), 32'(resp), 32'(vecs[i].expResp));
            if (vecs[i].chkData)
                checkOutput($sformatf("vec%0d.rdata", i), rdata, vecs[i].expData);
        end

        // Reset asserted during the WAIT of a write discards that write.
        applyStimulus(1, 3'b010, 32'h010, 32'hCAFEF00D, rdata, waits, resp, lowResp);
        hsel1 = 1'b1; htrans1 = 2'b10; hwrite1 = 1'b1; hsize1 = 3'b010; haddr1 = 32'h010;
        @(negedge clk);
        hsel1 = 1'b0; htrans1 = 2'b00; hwdata1 = 32'h11111111;
        checkOutput("abort.inWait", 32'(hreadyout1), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("abort.ready", 32'(hreadyout1), 32'd1);
        checkOutput("abort.resp",  32'(hresp1),     32'd0);
        checkOutput("abort.rdata", hrdata1,         32'h0);
        repeat (3) @(negedge clk);
        checkOutput("abort.readyHeld", 32'(hreadyout1), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(0, 3'b010, 32'h010, 32'h0, rdata, waits, resp, lowResp);
        checkOutput("abort.readBack", rdata, 32'hCAFEF00D);

        // Interleaved BUSY and unselected NONSEQ phases must never start a transfer.
        for (int k = 0; k < 6; k++) begin
            hsel1   = (k % 2 == 0);
            htrans1 = (k % 2 == 0) ? 2'b01 : 2'b10;
            hwrite1 = 1'b1; hsize1 = 3'b010; haddr1 = 32'h020; hwdata1 = 32'h0;
            @(negedge clk);
            checkOutput($sformatf("idle%0d.ready", k), 32'(hreadyout1), 32'd1);
            checkOutput($sformatf("idle%0d.resp", k),  32'(hresp1),     32'd0);
        end
        hsel1 = 1'b0; htrans1 = 2'b00;
        @(negedge clk);
        applyStimulus(0, 3'b010, 32'h020, 32'h0, rdata, waits, resp, lowResp);
        checkOutput("idle.readBack", rdata, 32'hDEADBEEF);

        // Zero-wait instance: a write followed by a pipelined read of the same word.
        hsel0 = 1'b1; htrans0 = 2'b10; hwrite0 = 1'b1; hsize0 = 3'b010; haddr0 = 32'h100;
        @(negedge clk);
        checkOutput("pipe.wrReady", 32'(hreadyout0), 32'd1);
        hwdata0 = 32'h00000005; hwrite0 = 1'b0;
        @(negedge clk);
        hsel0 = 1'b0; htrans0 = 2'b00; hwdata0 = 32'hFFFFFFFF;
        checkOutput("pipe.rdReady", 32'(hreadyout0), 32'd1);
        checkOutput("pipe.rdata",   hrdata0,         32'h00000005);
        @(negedge clk);
        checkOutput("pipe.idleReady", 32'(hreadyout0), 32'd1);
        checkOutput("pipe.idleRdata", hrdata0,         32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
